pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 104 ++++++++++
 tb/tb_pipe_chain.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: a DEPTH-stage valid/ready register pipeline with bubble
// collapsing, a global enable that freezes every stage, a synchronous flush
// of all valid bits, and a registered occupancy count.
module pipe_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int               OCC_W   = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    // Stage state: index 0 faces the input, index DEPTH-1 drives out_data.
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // r[i] says stage i may take a new value this cycle; r[DEPTH] is downstream.
    logic [DEPTH:0]   r;

    // What each stage would load if it advances.
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];

    logic advance;
    logic accept;
    logic emit;

    // Stages only move when enabled and not being flushed; handshakes follow.
    assign advance   = en && !flush;
    assign in_ready  = advance && r[0];
    assign out_valid = advance && v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // Ready ripples from the output back to the input: an empty stage absorbs a stall.
    always_comb begin
        logic carry;
        carry    = out_ready;
        r        = '0;
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry = !v[i] || carry;
            r[i]  = carry;
        end
    end

    // Upstream source for every stage: the chain input for stage 0, the previous stage otherwise.
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    // Stage registers: advancing stages copy upstream valid, and data only when that valid is set.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
        end
    end

    // Occupancy tracks items in flight: up on accept alone, down on emit alone.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (accept && !emit) begin
            occupancy <= occupancy + OCC_ONE;
        end else if (emit && !accept) begin
            occupancy <= occupancy - OCC_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed bench for pipe_chain with an item-position model
// checked on every falling edge, plus literal expectations per scenario.
module tb_pipe_chain;

    localparam int          WIDTH   = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_VAL = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    logic [31:0] got [$];

    int lat_occ [5] = '{1, 1, 1, 1, 0};
    int lat_ov  [5] = '{0, 0, 0, 1, 0};

    pipe_chain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Model: oldest-first list of items, each with the stage it currently occupies.
    typedef struct {
        logic [31:0] data;
        int          pos;
    } item_t;

    item_t       mq [$];
    logic [31:0] m_last = RST_VAL;

    // An item moves one stage forward unless the item ahead of it ends up right in front.
    function automatic bit m_can_accept(input bit ordy);
        int limit;
        int np;
        int first;
        limit = DEPTH - 1;
        np    = DEPTH;
        first = 0;
        if (mq.size() > 0 && mq[0].pos == DEPTH - 1 && ordy) first = 1;
        for (int k = first; k < mq.size(); k++) begin
            np    = (mq[k].pos + 1 < limit) ? mq[k].pos + 1 : limit;
            limit = np - 1;
        end
        return np >= 1;
    endfunction

    task automatic m_step();
        int  limit;
        int  np;
        bit  acc;
        acc   = in_valid && m_can_accept(out_ready);
        limit = DEPTH - 1;
        if (mq.size() > 0 && mq[0].pos == DEPTH - 1 && out_ready) void'(mq.pop_front());
        for (int k = 0; k < mq.size(); k++) begin
            np        = (mq[k].pos + 1 < limit) ? mq[k].pos + 1 : limit;
            mq[k].pos = np;
            limit     = np - 1;
            if (np == DEPTH - 1) m_last = mq[k].data;
        end
        if (acc) begin
            mq.push_back('{data: in_data, pos: 0});
            if (DEPTH == 1) m_last = in_data;
        end
    endtask

    // Model advances on every rising edge outside reset.
    always @(posedge clk) begin
        if (clr_n) begin
            if (flush) mq.delete();
            else if (en) m_step();
        end
    end

    // Reset empties the model immediately, like the hardware.
    always @(negedge clr_n) begin
        mq.delete();
        m_last = RST_VAL;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Every falling edge: compare all outputs to the model.
    always @(negedge clk) begin
        check("model.in_ready", in_ready, en && !flush && m_can_accept(out_ready));
        check("model.out_valid", out_valid,
              en && !flush && mq.size() > 0 && mq[0].pos == DEPTH - 1);
        check("model.out_data", out_data, m_last);
        check("model.occupancy", occupancy, mq.size());
    end

    task automatic applyStimulus(input bit iv, input logic [31:0] dat, input bit e,
                                 input bit fl, input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = dat;
        en        = e;
        flush     = fl;
        out_ready = ordy;
        #2;
    endtask

    task automatic checkOutput(input string tag, input bit rdy, input bit ov, input int occ);
        check({tag, ".in_ready"}, in_ready, rdy);
        check({tag, ".out_valid"}, out_valid, ov);
        check({tag, ".occupancy"}, occupancy, occ);
    endtask

    task automatic drainCollect(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            if (out_valid && out_ready) got.push_back(out_data);
        end
    endtask

    // Runaway guard.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed scenarios.
    initial begin
        clr_n = 1'b0; en = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        #8;
        checkOutput("reset", 1'b0, 1'b0, 0);
        check("reset.out_data", out_data, RST_VAL);
        #4;
        clr_n = 1'b1;

        $display("[TB] latency");
        applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0, 1'b1);
        checkOutput("lat.pre", 1'b1, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            check("lat.occupancy", occupancy, lat_occ[k]);
            check("lat.out_valid", out_valid, lat_ov[k]);
            if (k == 3) check("lat.out_data", out_data, 32'hA5);
        end
        check("lat.model_last", m_last, 32'hA5);

        $display("[TB] backpressure");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, i, 1'b1, 1'b0, 1'b0);
            check("bp.in_ready", in_ready, 1'b1);
        end
        applyStimulus(1'b1, 32'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("bp.full", 1'b0, 1'b1, 4);
        check("bp.full.out_data", out_data, 32'd1);
        check("bp.model_size", mq.size(), 4);
        applyStimulus(1'b1, 32'd5, 1'b1, 1'b0, 1'b1);
        checkOutput("bp.release", 1'b1, 1'b1, 4);
        check("bp.release.out_data", out_data, 32'd1);
        for (int j = 2; j <= 5; j++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            check("bp.drain.out_data", out_data, j);
            check("bp.drain.out_valid", out_valid, 1'b1);
            check("bp.drain.occupancy", occupancy, 6 - j);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("bp.empty.occupancy", occupancy, 0);

        $display("[TB] pass-through");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h10 + i, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b1);
        checkOutput("pt.full", 1'b1, 1'b1, 4);
        check("pt.full.out_data", out_data, 32'h10);
        applyStimulus(1'b1, 32'h15, 1'b1, 1'b0, 1'b1);
        checkOutput("pt.stream1", 1'b1, 1'b1, 4);
        check("pt.stream1.out_data", out_data, 32'h11);
        applyStimulus(1'b1, 32'h16, 1'b1, 1'b0, 1'b1);
        checkOutput("pt.stream2", 1'b1, 1'b1, 4);
        check("pt.stream2.out_data", out_data, 32'h12);
        got.delete();
        drainCollect(6);
        check("pt.drain.count", got.size(), 4);
        for (int k = 0; k < got.size(); k++) check("pt.drain.item", got[k], 32'h13 + k);
        check("pt.drain.occupancy", occupancy, 0);

        $display("[TB] enable freeze");
        applyStimulus(1'b1, 32'h21, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h23, 1'b0, 1'b0, 1'b1);
            checkOutput("frz", 1'b0, 1'b0, 2);
            check("frz.out_data", out_data, 32'h16);
        end
        got.delete();
        drainCollect(6);
        check("frz.resume.count", got.size(), 2);
        for (int k = 0; k < got.size(); k++) check("frz.resume.item", got[k], 32'h21 + k);

        $display("[TB] flush");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 32'h30 + i, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h34, 1'b0, 1'b1, 1'b0);
        checkOutput("fl.cycle", 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("fl.after", 1'b1, 1'b0, 0);
        check("fl.after.out_data", out_data, 32'h22);
        got.delete();
        applyStimulus(1'b1, 32'h35, 1'b1, 1'b0, 1'b1);
        drainCollect(6);
        check("fl.post.count", got.size(), 1);
        if (got.size() > 0) check("fl.post.item", got[0], 32'h35);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h41, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h42, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst.pre", 1'b1, 1'b1, 2);
        check("rst.pre.out_data", out_data, 32'h41);
        #1;
        clr_n = 1'b0;
        #1;
        checkOutput("rst.mid", 1'b1, 1'b0, 0);
        check("rst.mid.out_data", out_data, RST_VAL);
        @(posedge clk);
        #2;
        clr_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h43;
        out_ready = 1'b1;
        #1;
        check("rst.release.in_ready", in_ready, 1'b1);
        got.delete();
        drainCollect(6);
        check("rst.release.count", got.size(), 1);
        if (got.size() > 0) check("rst.release.item", got[0], 32'h43);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
